// File: rtl/kitt_pwm_capture_if.sv
// Result bus of kitt_pwm_capture: channel select in, latched frame results out.
interface kitt_pwm_capture_if #(
  parameter int LVL_W = 3
);
  logic [2:0]       sel;
  logic [LVL_W-1:0] level_out;
  logic             frame_done;
  logic [7:0]       active_mask;
  logic [2:0]       peak_ch;
  logic             peak_valid;

  modport slave (
    input  sel,
    output level_out, frame_done, active_mask, peak_ch, peak_valid
  );

  modport master (
    output sel,
    input  level_out, frame_done, active_mask, peak_ch, peak_valid
  );
endinterface

// File: rtl/kitt_pwm_capture.sv
// Eight-channel PWM duty capture over a free-running 2^CNT_W frame.
// Optional 2-sample glitch filter enabled by defining PWMCAP_GLITCH_FILTER_EN.
module kitt_pwm_capture #(
  parameter int CNT_W = 8,
  parameter int LVL_W = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          pwm_in,
  kitt_pwm_capture_if.slave   cap
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W:0]   SAT_MAX = {1'b0, {CNT_W{1'b1}}};

  logic [7:0]       sync1_q, sync1_d, sync2_q, sync2_d;
  logic [7:0]       sample;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [CNT_W:0]   acc_q [8];
  logic [CNT_W:0]   acc_d [8];
  logic [CNT_W:0]   cnt_final [8];
  logic [CNT_W-1:0] sat [8];
  logic [CNT_W-1:0] best;
  logic [2:0]       best_idx;
  logic             wrap;
  logic [LVL_W-1:0] level_q [8];
  logic [LVL_W-1:0] level_d [8];
  logic [7:0]       mask_q, mask_d;
  logic [2:0]       peak_q, peak_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;

  always_comb begin
    sync1_d = pwm_in;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

`ifdef PWMCAP_GLITCH_FILTER_EN
  logic [7:0] prev_q, prev_d, filt_q, filt_d;

  // Output follows the synchronized bit only once it matched on two consecutive cycles.
  always_comb begin
    prev_d = sync2_q;
    filt_d = filt_q;
    for (int unsigned i = 0; i < 8; i++) begin
      if (sync2_q[i] == prev_q[i]) filt_d[i] = sync2_q[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= '0;
      filt_q <= '0;
    end else begin
      prev_q <= prev_d;
      filt_q <= filt_d;
    end
  end

  assign sample = filt_q;
`else
  assign sample = sync2_q;
`endif

  always_comb begin
    frame_cnt_d = frame_cnt_q + 1'b1;
    wrap        = (frame_cnt_q == CNT_MAX);
    best        = '0;
    best_idx    = '0;
    level_d     = level_q;
    mask_d      = mask_q;
    peak_d      = peak_q;
    valid_d     = valid_q;
    done_d      = wrap;
    for (int unsigned i = 0; i < 8; i++) begin
      cnt_final[i] = acc_q[i] + {{CNT_W{1'b0}}, sample[i]};
      acc_d[i]     = (frame_cnt_q == '0) ? {{CNT_W{1'b0}}, sample[i]} : cnt_final[i];
      sat[i]       = (cnt_final[i] > SAT_MAX) ? SAT_MAX[CNT_W-1:0] : cnt_final[i][CNT_W-1:0];
      // Strict compare keeps the lowest index on ties.
      if (sat[i] > best) begin
        best     = sat[i];
        best_idx = 3'(i);
      end
    end
    if (wrap) begin
      for (int unsigned i = 0; i < 8; i++) begin
        level_d[i] = sat[i][CNT_W-1 -: LVL_W];
        mask_d[i]  = (cnt_final[i] != '0);
      end
      peak_d  = best_idx;
      valid_d = |mask_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt_q <= '0;
      for (int unsigned i = 0; i < 8; i++) begin
        acc_q[i]   <= '0;
        level_q[i] <= '0;
      end
      mask_q  <= '0;
      peak_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      for (int unsigned i = 0; i < 8; i++) begin
        acc_q[i]   <= acc_d[i];
        level_q[i] <= level_d[i];
      end
      mask_q  <= mask_d;
      peak_q  <= peak_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign cap.level_out   = level_q[cap.sel];
  assign cap.frame_done  = done_q;
  assign cap.active_mask = mask_q;
  assign cap.peak_ch     = peak_q;
  assign cap.peak_valid  = valid_q;
endmodule

// File: doc/kitt_pwm_capture.md
# kitt_pwm_capture

Receive-side companion to the KITT scanner PWM output stage. It samples eight PWM lines, which are normally the scanner's own PWM outputs looped back through the bidirectional pins, and measures each channel's duty cycle over a fixed frame. It reports a per-channel brightness level, an activity mask and the brightest channel, i.e. the current scanner head position. It is used for on-chip self-test and for boards that chain two scanners.

## Interface
Parameters:
- CNT_W, 8: frame length is 2^CNT_W clock cycles; width of per-channel high-time accumulators.
- LVL_W, 3: width of the reported brightness level; LVL_W <= CNT_W.

Ports:
- clk, input, 1: system clock (10 MHz nominal).
- rst, input, 1: asynchronous, active-high reset.
- pwm_in, input, 8: asynchronous PWM lines, channel i on bit i.
- sel, input, 3: channel selected onto level_out.
- level_out, output, LVL_W: latched level of channel sel.
- frame_done, output, 1: one-cycle pulse when a new frame result is latched.
- active_mask, output, 8: bit i set if channel i was high at least one cycle in the last frame.
- peak_ch, output, 3: channel with the largest high count in the last frame.
- peak_valid, output, 1: equals |active_mask.

## Operation
- Input path:
  - Each pwm_in bit passes a 2-flop synchronizer, reset value 0.
  - The result then passes the optional glitch filter (see Configuration).
- Frame counter:
  - CNT_W bits, cleared by reset, increments every cycle and wraps from 2^CNT_W-1 to 0.
  - It is free-running and is not aligned to transmitter phase. Any window of whole PWM periods yields the correct duty.
- Accumulators:
  - 8 accumulators, each CNT_W+1 bits.
  - On frame_cnt==0 each loads the filtered sample (0 or 1); otherwise it adds the sample.
- Latch, on the cycle where frame_cnt==2^CNT_W-1, for each channel:
  - cnt_final = accumulator + current sample.
  - This is saturated to 2^CNT_W-1, so a constantly high input reads full scale.
  - level[i] = saturated count[CNT_W-1 -: LVL_W], i.e. truncated, not rounded.
  - active_mask[i] = (cnt_final != 0).
  - peak_ch = index of the maximum saturated count. On a tie the lowest index wins. If all counts are 0, peak_ch = 0.
- level_out = level[sel]. This is a combinational mux of registered levels, so a change on sel is visible in the same cycle.
- Outputs hold their values between frames.

## Timing
- Reset values: level registers 0, level_out 0, frame_done 0, active_mask 0x00, peak_ch 0, peak_valid 0, frame_cnt 0, accumulators 0.
- Input latency: 2 cycles through the synchronizer, plus 2 more with the glitch filter.
- Frame results update on the clock edge at which frame_cnt==2^CNT_W-1.
  - frame_done is high for exactly the following cycle.
  - The first frame_done comes after the 2^CNT_W-th rising edge following reset deassertion, i.e. cycle 256 for CNT_W=8.
- Reset asserted mid-frame:
  - All state clears immediately (asynchronous) and the partial frame is discarded.
  - Counting restarts from frame_cnt=0 on the first edge after release.
- A sample arriving in the wrap cycle belongs to the frame being closed. The sample in the next cycle starts the new accumulation.
- frame_done is never asserted on two consecutive cycles. The period is exactly 2^CNT_W cycles.

## Configuration
- Macro PWMCAP_GLITCH_FILTER_EN.
- Defined:
  - Each synchronized bit feeds a 2-sample stability filter.
  - The filtered value changes only after the new value has been seen on 2 consecutive cycles.
  - Single-cycle pulses are rejected.
  - Adds 2 cycles of input latency.
- Undefined:
  - filtered = synchronized value.
  - No extra latency; every sampled high cycle is counted.

## Test plan
All scenarios use CNT_W=8 and LVL_W=3.
- pwm_in=0x00 held -> at the first frame_done: level_out=0 for every sel, active_mask=0x00, peak_valid=0, peak_ch=0.
- pwm_in=0x08 held -> from the second frame onward: sel=3 gives level_out=7 (count saturated 255), active_mask=0x08, peak_ch=3, peak_valid=1.
- Channel 5 driven 64 high / 192 low, period 256 -> count 64, level_out=2 at sel=5, active_mask=0x20, regardless of phase relative to frame_cnt.
- Channels 1 and 6 both at 50% duty (period 16) -> both levels 4, peak_ch=1 (tie goes to lowest index), active_mask=0x42.
- Assert rst for 3 cycles at frame_cnt≈100 with pwm_in=0xFF -> all outputs 0 immediately; the next frame_done comes 256 edges after release, with all levels 7.
- Single-cycle pulse on pwm_in[2] per frame, all else 0 -> macro defined: active_mask=0x00, peak_valid=0. Macro undefined: active_mask=0x04, level 0, peak_ch=2.
